reg_transfer_sequencer: RTL and testbench
=========================================

Name: reg_transfer_sequencer

Overview:
- Hardwired control unit that drives the DataPath register-transfer control lines: RAout, RBout, RZout, RAin, RBin, RZin, AddImmediate and RegisterAImmediate.
- Accepts one encoded instruction at a time over a valid/ready handshake. Expands it into a sequence of one-cycle control steps (T-states) and pulses done on completion.
- Sits between the instruction source and DataPath; it replaces hand-sequenced control stimulus.

Parameters:
- DATA_W, 8, width of the immediate field and of the AddImmediate and RegisterAImmediate outputs.

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- clear_n  input  1  reset.
  - One clock; reset is asynchronous and active-low.
- instr_valid  input  1  instruction fields are valid this cycle.
- instr_ready  output  1  sequencer can accept an instruction.
- opcode  input  2  00 NOP, 01 LDI, 10 ADDI, 11 MV.
- dst  input  1  destination register: 0=A, 1=B.
- src  input  1  source register: 0=A, 1=B (ADDI and MV only).
- imm  input  DATA_W  immediate (LDI and ADDI only).
- RAout, RBout, RZout  output  1 each  drive A, B or Z onto the DataPath bus.
- RAin, RBin, RZin  output  1 each  load A, B or Z.
- AddImmediate  output  DATA_W  adder immediate operand.
- RegisterAImmediate  output  DATA_W  direct immediate load value for A.
- done  output  1  one-cycle pulse when an instruction completes.

Behaviour:
- States:
  - IDLE, S1, S2.
  - instr_ready = (state==IDLE), decoded combinationally.
  - All control outputs and done are registered.
- Reset (clear_n low, asynchronous):
  - State goes to IDLE immediately; all control outputs and done go to 0.
  - instr_ready reads 1 while reset is held and after release.
  - A reset in S1 or S2 aborts the instruction immediately; no further control steps are issued and done is not pulsed.
- Accept:
  - Occurs on a rising edge with instr_valid && instr_ready.
  - opcode, dst, src and imm are latched internally on that edge.
  - The state moves to S1, and the S1 controls are driven from that edge for exactly one cycle.
  - Inputs are ignored while not in IDLE.
- Step encoding (every signal not listed is 0):
  - NOP: S1 drives no controls.
  - LDI dst=A: S1 RegisterAImmediate=imm, RAin=1.
  - LDI dst=B:
    - S1 AddImmediate=imm, RZin=1, with no out asserted, so the bus is 0 and Z=imm.
    - S2 RZout=1, RBin=1.
  - ADDI dst,src:
    - S1 src out (RAout or RBout), AddImmediate=imm, RZin=1.
    - S2 RZout=1, dst in (RAin or RBin).
  - MV dst,src with dst!=src: S1 src out, dst in.
  - MV dst,src with dst==src: S1 drives no controls.
- Completion:
  - After the last step the next edge returns the state to IDLE, clears all controls and sets done=1 for that one cycle.
  - A new instruction may be accepted on the edge that ends the done cycle.
  - Throughput is one instruction per 2 cycles for single-step instructions and per 3 cycles for two-step instructions.
- Invariants, checked every cycle:
  - At most one of RAout, RBout and RZout is high.
  - At most one of RAin, RBin and RZin is high.
  - RZout and RZin are never high together.
  - AddImmediate=0 unless RZin=1.
  - RegisterAImmediate=0 unless RAin=1 with no out asserted.
  - Every control output is high for exactly one cycle per step; there are no glitches, since the outputs come from flops.
- Arithmetic: none in this block; imm is passed through unmodified (DATA_W bits, no extension).

Test Plan:
- Reset then LDI A,5 (opcode 01, dst 0, imm 8'h05):
  - Accept edge, then one cycle of RegisterAImmediate=8'h05 and RAin=1.
  - Next cycle: done=1, all controls 0, instr_ready=1.
- ADDI B,A,5 presented back-to-back after LDI A,5:
  - S1 RAout=1, AddImmediate=8'h05, RZin=1.
  - S2 RZout=1, RBin=1.
  - Then done; with the DataPath attached, B reads 8'h0A.
- LDI B,8'hFF:
  - S1 AddImmediate=8'hFF, RZin=1, all outs 0.
  - S2 RZout=1, RBin=1.
  - Then done; B reads 8'hFF.
- MV A,B and MV B,B:
  - MV A,B: single cycle RBout=1, RAin=1, then done.
  - MV B,B: one cycle of all controls 0, then done.
- Hold instr_valid=1 with changing fields during S1/S2 of ADDI:
  - instr_ready=0 throughout and the fields are ignored.
  - The held instruction is accepted only on the edge after the done cycle.
- Assert clear_n=0 mid-cycle during S1 of ADDI:
  - All controls drop to 0 asynchronously.
  - No S2 step and no done pulse occur.
  - instr_ready=1 after release.

Source files
------------

// File: rtl/reg_transfer_sequencer.sv
// Hardwired control sequencer for the DataPath register-transfer lines.
// Expands one NOP/LDI/ADDI/MV instruction into registered one-cycle T-state steps, then pulses done.
module reg_transfer_sequencer #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clock,
  input  logic              clear_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [1:0]        opcode,
  input  logic              dst,
  input  logic              src,
  input  logic [DATA_W-1:0] imm,
  output logic              RAout,
  output logic              RBout,
  output logic              RZout,
  output logic              RAin,
  output logic              RBin,
  output logic              RZin,
  output logic [DATA_W-1:0] AddImmediate,
  output logic [DATA_W-1:0] RegisterAImmediate,
  output logic              done
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_S1   = 2'b01;
  localparam logic [1:0] ST_S2   = 2'b10;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_LDI  = 2'b01;
  localparam logic [1:0] OP_ADDI = 2'b10;
  localparam logic [1:0] OP_MV   = 2'b11;

  logic [1:0]        r_state;
  logic [1:0]        r_op;
  logic              r_dst;
  logic              r_raout, r_rbout, r_rzout, r_rain, r_rbin, r_rzin, r_done;
  logic [DATA_W-1:0] r_addimm, r_raimm;

  logic [1:0]        w_state_nxt;
  logic [1:0]        w_op_nxt;
  logic              w_dst_nxt;
  logic              w_raout, w_rbout, w_rzout, w_rain, w_rbin, w_rzin, w_done;
  logic [DATA_W-1:0] w_addimm, w_raimm;

  assign instr_ready = (r_state == ST_IDLE);

  // S1 controls are decoded straight from the inputs on the accept edge;
  // only opcode and dst are needed afterwards to form the S2 step.
  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    w_dst_nxt   = r_dst;
    w_raout     = 1'b0;
    w_rbout     = 1'b0;
    w_rzout     = 1'b0;
    w_rain      = 1'b0;
    w_rbin      = 1'b0;
    w_rzin      = 1'b0;
    w_done      = 1'b0;
    w_addimm    = '0;
    w_raimm     = '0;
    case (r_state)
      ST_IDLE: begin
        if (instr_valid) begin
          w_state_nxt = ST_S1;
          w_op_nxt    = opcode;
          w_dst_nxt   = dst;
          case (opcode)
            OP_LDI: begin
              if (!dst) begin
                w_raimm = imm;
                w_rain  = 1'b1;
              end else begin
                w_addimm = imm;
                w_rzin   = 1'b1;
              end
            end
            OP_ADDI: begin
              w_raout  = ~src;
              w_rbout  = src;
              w_addimm = imm;
              w_rzin   = 1'b1;
            end
            OP_MV: begin
              if (dst != src) begin
                w_raout = ~src;
                w_rbout = src;
                w_rain  = ~dst;
                w_rbin  = dst;
              end
            end
            default: ;
          endcase
        end
      end
      ST_S1: begin
        if (r_op == OP_ADDI || (r_op == OP_LDI && r_dst)) begin
          w_state_nxt = ST_S2;
          w_rzout     = 1'b1;
          w_rain      = ~r_dst;
          w_rbin      = r_dst;
        end else begin
          w_state_nxt = ST_IDLE;
          w_done      = 1'b1;
        end
      end
      ST_S2: begin
        w_state_nxt = ST_IDLE;
        w_done      = 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_state  <= ST_IDLE;
      r_op     <= OP_NOP;
      r_dst    <= 1'b0;
      r_raout  <= 1'b0;
      r_rbout  <= 1'b0;
      r_rzout  <= 1'b0;
      r_rain   <= 1'b0;
      r_rbin   <= 1'b0;
      r_rzin   <= 1'b0;
      r_done   <= 1'b0;
      r_addimm <= '0;
      r_raimm  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_op     <= w_op_nxt;
      r_dst    <= w_dst_nxt;
      r_raout  <= w_raout;
      r_rbout  <= w_rbout;
      r_rzout  <= w_rzout;
      r_rain   <= w_rain;
      r_rbin   <= w_rbin;
      r_rzin   <= w_rzin;
      r_done   <= w_done;
      r_addimm <= w_addimm;
      r_raimm  <= w_raimm;
    end
  end

  assign RAout              = r_raout;
  assign RBout              = r_rbout;
  assign RZout              = r_rzout;
  assign RAin               = r_rain;
  assign RBin               = r_rbin;
  assign RZin               = r_rzin;
  assign done               = r_done;
  assign AddImmediate       = r_addimm;
  assign RegisterAImmediate = r_raimm;

endmodule

// File: tb/tb_reg_transfer_sequencer.sv
// Scoreboard bench: each accepted instruction queues its expected per-cycle control vectors.
module tb_reg_transfer_sequencer;

  localparam int unsigned DATA_W = 8;

  logic              clock = 1'b0;
  logic              clear_n;
  logic              instr_valid;
  logic              instr_ready;
  logic [1:0]        opcode;
  logic              dst, src;
  logic [DATA_W-1:0] imm;
  logic              RAout, RBout, RZout, RAin, RBin, RZin, done;
  logic [DATA_W-1:0] AddImmediate, RegisterAImmediate;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic        mon_en   = 1'b0;
  logic [23:0] exp_q[$];

  reg_transfer_sequencer #(.DATA_W(DATA_W)) dut (
    .clock(clock), .clear_n(clear_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .dst(dst), .src(src), .imm(imm),
    .RAout(RAout), .RBout(RBout), .RZout(RZout), .RAin(RAin), .RBin(RBin), .RZin(RZin),
    .AddImmediate(AddImmediate), .RegisterAImmediate(RegisterAImmediate), .done(done)
  );

  always #5 clock = ~clock;

  // {ready, done, RAout, RBout, RZout, RAin, RBin, RZin, AddImmediate, RegisterAImmediate}
  function automatic logic [23:0] mkvec(logic rdy, logic dn, logic ao, logic bo, logic zo,
                                        logic ai, logic bi, logic zi,
                                        logic [7:0] addi, logic [7:0] raim);
    return {rdy, dn, ao, bo, zo, ai, bi, zi, addi, raim};
  endfunction

  function automatic logic [23:0] observed();
    return {instr_ready, done, RAout, RBout, RZout, RAin, RBin, RZin, AddImmediate, RegisterAImmediate};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, want, $time);
    end
  endtask

  // Expected control steps taken from the instruction step table, followed by the done cycle.
  task automatic push_expect(input logic [1:0] op, input logic d, input logic s,
                             input logic [7:0] im, output int unsigned nsteps);
    nsteps = 1;
    case (op)
      2'b01: begin
        if (!d) exp_q.push_back(mkvec(0,0, 0,0,0, 1,0,0, 8'h00, im));
        else begin
          exp_q.push_back(mkvec(0,0, 0,0,0, 0,0,1, im, 8'h00));
          exp_q.push_back(mkvec(0,0, 0,0,1, 0,1,0, 8'h00, 8'h00));
          nsteps = 2;
        end
      end
      2'b10: begin
        exp_q.push_back(mkvec(0,0, !s,s,0, 0,0,1, im, 8'h00));
        exp_q.push_back(mkvec(0,0, 0,0,1, !d,d,0, 8'h00, 8'h00));
        nsteps = 2;
      end
      2'b11: begin
        if (d != s) exp_q.push_back(mkvec(0,0, !s,s,0, !d,d,0, 8'h00, 8'h00));
        else        exp_q.push_back(mkvec(0,0, 0,0,0, 0,0,0, 8'h00, 8'h00));
      end
      default: exp_q.push_back(mkvec(0,0, 0,0,0, 0,0,0, 8'h00, 8'h00));
    endcase
    exp_q.push_back(mkvec(1,1, 0,0,0, 0,0,0, 8'h00, 8'h00));
  endtask

  // Called at a negedge while the DUT is idle (or in its done cycle); returns at the
  // negedge inside the done cycle so the next call is accepted back-to-back.
  task automatic send(input logic [1:0] op, input logic d, input logic s,
                      input logic [7:0] im, input logic hold);
    int unsigned nst;
    chk("ready_before_accept", {31'd0, instr_ready}, 32'd1);
    opcode = op; dst = d; src = s; imm = im; instr_valid = 1'b1;
    push_expect(op, d, s, im, nst);
    @(negedge clock);
    for (int unsigned i = 0; i < nst; i++) begin
      if (hold) begin
        instr_valid = 1'b1;
        opcode = 2'($urandom); dst = 1'($urandom); src = 1'($urandom); imm = 8'($urandom);
      end else begin
        instr_valid = 1'b0;
      end
      @(negedge clock);
    end
  endtask

  initial begin : monitor
    forever begin
      @(posedge clock);
      #1;
      if (mon_en) begin
        if (exp_q.size() > 0) chk("ctl_step", {8'd0, observed()}, {8'd0, exp_q.pop_front()});
        else                  chk("ctl_idle", {8'd0, observed()}, {8'd0, mkvec(1,0, 0,0,0, 0,0,0, 8'h00, 8'h00)});
      end
    end
  end

  initial begin : stim
    clear_n = 1'b0; instr_valid = 1'b0; opcode = '0; dst = 1'b0; src = 1'b0; imm = '0;
    repeat (3) @(negedge clock);
    chk("reset_ctl", {8'd0, observed()}, {8'd0, mkvec(1,0, 0,0,0, 0,0,0, 8'h00, 8'h00)});
    clear_n = 1'b1;
    mon_en  = 1'b1;
    @(negedge clock);

    send(2'b01, 1'b0, 1'b0, 8'h05, 1'b0);   // LDI A,5
    send(2'b10, 1'b1, 1'b0, 8'h05, 1'b0);   // ADDI B,A,5 back-to-back
    send(2'b01, 1'b1, 1'b0, 8'hFF, 1'b0);   // LDI B,FF
    send(2'b11, 1'b0, 1'b1, 8'h77, 1'b0);   // MV A,B
    send(2'b11, 1'b1, 1'b1, 8'h77, 1'b0);   // MV B,B
    send(2'b00, 1'b0, 1'b0, 8'h3C, 1'b0);   // NOP
    send(2'b10, 1'b0, 1'b1, 8'h33, 1'b1);   // ADDI A,B,33 with valid held and noisy fields
    send(2'b11, 1'b1, 1'b0, 8'h00, 1'b0);   // held instruction: MV B,A
    instr_valid = 1'b0;
    repeat (3) @(negedge clock);

    // asynchronous abort during S1 of ADDI
    opcode = 2'b10; dst = 1'b1; src = 1'b1; imm = 8'h44; instr_valid = 1'b1;
    exp_q.push_back(mkvec(0,0, 0,1,0, 0,0,1, 8'h44, 8'h00));
    @(posedge clock);
    #3;
    clear_n = 1'b0;
    instr_valid = 1'b0;
    exp_q.delete();
    #1;
    chk("abort_ctl", {8'd0, observed()}, {8'd0, mkvec(1,0, 0,0,0, 0,0,0, 8'h00, 8'h00)});
    @(negedge clock);
    @(negedge clock);
    clear_n = 1'b1;
    repeat (4) @(negedge clock);
    chk("ready_after_abort", {31'd0, instr_ready}, 32'd1);

    send(2'b01, 1'b0, 1'b0, 8'hA5, 1'b0);   // LDI A,A5 after abort
    instr_valid = 1'b0;
    for (int unsigned c = 0; c < 20 && exp_q.size() > 0; c++) @(negedge clock);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    repeat (2) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
